// File: rtl/ofdm_frame_sched.sv
// OFDM frame scheduler: walks N_FFT subcarriers for SYM_PER_FRAME symbols and emits
// null, pilot or source data per carrier into a single registered output stage.
module ofdm_frame_sched #(
    parameter int         N_FFT         = 64,
    parameter int         GUARD         = 6,
    parameter int         PILOT_STEP    = 8,
    parameter int         PILOT_OFF     = 4,
    parameter logic [1:0] PILOT_VAL     = 2'b00,
    parameter int         SYM_PER_FRAME = 4,
    parameter int         GAP_CYC       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic [1:0] data_src,
    input  logic       valid_src,
    output logic       ready_src,
    output logic [1:0] data_out,
    output logic [1:0] type_out,
    output logic       valid_out,
    input  logic       ready_out,
    output logic       sof_out,
    output logic       sos_out,
    output logic       eos_out,
    output logic       busy,
    output logic       done
);

    localparam int K_W   = $clog2(N_FFT);
    localparam int SYM_W = (SYM_PER_FRAME > 1) ? $clog2(SYM_PER_FRAME) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(N_FFT - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_PER_FRAME - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    localparam logic [1:0] TYPE_NULL  = 2'b00;
    localparam logic [1:0] TYPE_PILOT = 2'b01;
    localparam logic [1:0] TYPE_DATA  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN} state_t;

    // Null band is DC plus the centre guard; pilots sit on a fixed comb outside it.
    function automatic logic [1:0] carrier_class(input logic [K_W-1:0] k);
        int ki;
        ki = int'(k);
        if (ki == 0 || (ki >= N_FFT/2 - GUARD && ki <= N_FFT/2 + GUARD - 1))
            return TYPE_NULL;
        else if (ki % PILOT_STEP == PILOT_OFF)
            return TYPE_PILOT;
        else
            return TYPE_DATA;
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [K_W-1:0]     r_k;
    logic [SYM_W-1:0]   r_sym;
    logic [GAP_W-1:0]   r_gap;

    logic               r_valid_out;
    logic [1:0]         r_data_out;
    logic [1:0]         r_type_out;
    logic               r_sof;
    logic               r_sos;
    logic               r_eos;

    logic [1:0]         w_cls;
    logic [1:0]         w_word;
    logic               w_is_data;
    logic               w_last_k;
    logic               w_last_sym;
    logic               w_gap_end;
    logic               w_slot_free;
    logic               w_load;

    assign w_cls       = carrier_class(r_k);
    assign w_is_data   = (w_cls == TYPE_DATA);
    assign w_word      = w_is_data ? data_src : ((w_cls == TYPE_PILOT) ? PILOT_VAL : 2'b00);
    assign w_last_k    = (r_k == K_LAST);
    assign w_last_sym  = (r_sym == SYM_LAST);
    assign w_gap_end   = (r_gap == GAP_LAST);
    assign w_slot_free = !r_valid_out || ready_out;

    // State register; en low freezes the whole machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else if (en)
            r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (w_load && w_last_k) begin
                    if (w_last_sym)
                        w_state_next = S_DRAIN;
                    else if (GAP_CYC > 0)
                        w_state_next = S_GAP;
                    else
                        w_state_next = S_RUN;
                end
            end
            S_GAP:   if (w_gap_end) w_state_next = S_RUN;
            S_DRAIN: if (!r_valid_out) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Data carriers load only when the source presents a symbol; null/pilot never wait on it.
    always_comb begin
        ready_src = 1'b0;
        w_load    = 1'b0;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DRAIN) && !r_valid_out;
        if (en && r_state == S_RUN && w_slot_free) begin
            ready_src = w_is_data;
            w_load    = !w_is_data || valid_src;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k         <= '0;
            r_sym       <= '0;
            r_gap       <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= 2'b00;
            r_type_out  <= 2'b00;
            r_sof       <= 1'b0;
            r_sos       <= 1'b0;
            r_eos       <= 1'b0;
        end else if (en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (r_state == S_IDLE && start) begin
                r_k   <= '0;
                r_sym <= '0;
                r_gap <= '0;
            end
            if (r_state == S_GAP)
                r_gap <= w_gap_end ? '0 : r_gap + 1'b1;
            if (w_load) begin
                r_k <= r_k + 1'b1;
                if (w_last_k && !w_last_sym)
                    r_sym <= r_sym + 1'b1;
                r_gap       <= '0;
                r_valid_out <= 1'b1;
                r_data_out  <= w_word;
                r_type_out  <= w_cls;
                r_sof       <= (r_k == '0) && (r_sym == '0);
                r_sos       <= (r_k == '0);
                r_eos       <= w_last_k;
            end else if (r_valid_out && ready_out) begin
                r_valid_out <= 1'b0;
            end
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign type_out  = r_type_out;
    assign sof_out   = r_sof;
    assign sos_out   = r_sos;
    assign eos_out   = r_eos;

endmodule
